// File: rtl/rename_pkg.sv
// Shared widths and types for the rename stage: map table, checkpoint entries and reset map.
// Module parameters default to the DEF_* values here and must stay consistent with them.
package rename_pkg;

    localparam int DEF_WIDTH    = 4;
    localparam int DEF_ARF_SIZE = 32;
    localparam int DEF_PRF_SIZE = 64;
    localparam int DEF_CP_SIZE  = 4;

    localparam int ARF_W  = $clog2(DEF_ARF_SIZE);
    localparam int PRF_W  = $clog2(DEF_PRF_SIZE);
    localparam int CP_W   = $clog2(DEF_CP_SIZE);
    localparam int FCNT_W = $clog2(DEF_PRF_SIZE + 1);

    typedef logic [DEF_ARF_SIZE-1:0][PRF_W-1:0] map_t;

    typedef struct packed {
        map_t                    map;
        logic [DEF_PRF_SIZE-1:0] alloc_mask;
    } cp_entry_t;

    function automatic map_t reset_map();
        map_t m;
        for (int a = 0; a < DEF_ARF_SIZE; a++) begin
            m[a] = PRF_W'(a);
        end
        return m;
    endfunction

endpackage

// File: rtl/rename_freelist.sv
// Bitmap free list: WIDTH-way lowest-set-bit picking, free count, retire release and recover OR-in.
module rename_freelist
    import rename_pkg::*;
#(
    parameter int WIDTH    = DEF_WIDTH,
    parameter int ARF_SIZE = DEF_ARF_SIZE,
    parameter int PRF_SIZE = DEF_PRF_SIZE
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic [PRF_SIZE-1:0]      alloc_clear,
    input  logic                     recover,
    input  logic [PRF_SIZE-1:0]      recover_set,
    input  logic [WIDTH-1:0]         retire_valid,
    input  logic [WIDTH*PRF_W-1:0]   retire_prf,
    output logic [WIDTH*PRF_W-1:0]   pick,
    output logic [FCNT_W-1:0]        free_cnt
);

    logic [PRF_SIZE-1:0] free_q;
    logic [PRF_SIZE-1:0] free_d;
    logic [PRF_SIZE-1:0] retire_set;
    logic [PRF_SIZE-1:0] avail;

    // Pick k-th lowest free bit: descending scan so the lowest remaining bit wins.
    always_comb begin
        logic hit;
        avail = free_q;
        pick  = '0;
        for (int k = 0; k < WIDTH; k++) begin
            hit = 1'b0;
            for (int p = PRF_SIZE - 1; p >= 0; p--) begin
                if (avail[p]) begin
                    pick[k*PRF_W +: PRF_W] = PRF_W'(p);
                    hit = 1'b1;
                end
            end
            if (hit) begin
                avail[pick[k*PRF_W +: PRF_W]] = 1'b0;
            end
        end
    end

    always_comb begin
        free_cnt = '0;
        for (int p = 0; p < PRF_SIZE; p++) begin
            free_cnt = free_cnt + FCNT_W'(free_q[p]);
        end
    end

    always_comb begin
        retire_set = '0;
        for (int i = 0; i < WIDTH; i++) begin
            if (retire_valid[i]) begin
                retire_set[retire_prf[i*PRF_W +: PRF_W]] = 1'b1;
            end
        end
        free_d = (free_q & ~alloc_clear) | retire_set;
        if (recover) begin
            free_d = free_d | recover_set;
        end
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            for (int p = 0; p < PRF_SIZE; p++) begin
                free_q[p] <= (p >= ARF_SIZE);
            end
        end else begin
            free_q <= free_d;
        end
    end

    // Releasing p0 or an already-free register would corrupt the free count.
    always_ff @(posedge clock) begin
        if (reset) begin
            for (int i = 0; i < WIDTH; i++) begin
                if (retire_valid[i]) begin
                    assert (retire_prf[i*PRF_W +: PRF_W] != '0 &&
                            !free_q[retire_prf[i*PRF_W +: PRF_W]]);
                end
            end
        end
    end

endmodule

// File: rtl/rename_map_ckpt.sv
// Register rename stage: map table, free list and branch checkpoint ring with single-cycle recovery.
// Optional stall-cause counters are built when RENAME_STALL_CNT_EN is defined.
module rename_map_ckpt
    import rename_pkg::*;
#(
    parameter int WIDTH    = DEF_WIDTH,
    parameter int ARF_SIZE = DEF_ARF_SIZE,
    parameter int PRF_SIZE = DEF_PRF_SIZE,
    parameter int CP_SIZE  = DEF_CP_SIZE
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic [WIDTH-1:0]         in_valid,
    input  logic [WIDTH*ARF_W-1:0]   rs1,
    input  logic [WIDTH*ARF_W-1:0]   rs2,
    input  logic [WIDTH*ARF_W-1:0]   rd,
    input  logic [WIDTH-1:0]         rd_valid,
    input  logic                     cp_req,
    input  logic                     cp_release,
    input  logic                     recover,
    input  logic [CP_W-1:0]          recover_idx,
    input  logic [WIDTH-1:0]         retire_valid,
    input  logic [WIDTH*PRF_W-1:0]   retire_prf,
    output logic                     in_ready,
    output logic [WIDTH*PRF_W-1:0]   prs1,
    output logic [WIDTH*PRF_W-1:0]   prs2,
    output logic [WIDTH*PRF_W-1:0]   prd,
    output logic [WIDTH*PRF_W-1:0]   prev_prd,
`ifdef RENAME_STALL_CNT_EN
    output logic [31:0]              stall_free_cnt,
    output logic [31:0]              stall_cp_cnt,
`endif
    output logic [CP_W-1:0]          cp_idx
);

    map_t                 map_q;
    map_t                 map_d;
    cp_entry_t            cp_q [CP_SIZE];
    logic [CP_W-1:0]      cp_head_q;
    logic [CP_W:0]        cp_count_q;

    logic [WIDTH*PRF_W-1:0] pick;
    logic [FCNT_W-1:0]      free_cnt;
    logic [FCNT_W-1:0]      n_alloc;
    logic [PRF_SIZE-1:0]    alloc_bits;
    logic [PRF_SIZE-1:0]    alloc_clear;
    logic [PRF_SIZE-1:0]    recover_set;
    logic [CP_SIZE-1:0]     cp_live;
    logic [CP_W-1:0]        rec_dist;
    logic                   free_short;
    logic                   cp_full;
    logic                   fire;
    logic                   cp_take;
    logic                   cp_rel;

    // Sequential walk over slots gives RAW forwarding and WAW chaining for free.
    always_comb begin
        int k;
        k          = 0;
        map_d      = map_q;
        prs1       = '0;
        prs2       = '0;
        prd        = '0;
        prev_prd   = '0;
        alloc_bits = '0;
        for (int i = 0; i < WIDTH; i++) begin
            prs1[i*PRF_W +: PRF_W] = map_d[rs1[i*ARF_W +: ARF_W]];
            prs2[i*PRF_W +: PRF_W] = map_d[rs2[i*ARF_W +: ARF_W]];
            if (in_valid[i] && rd_valid[i] && rd[i*ARF_W +: ARF_W] != '0) begin
                prd[i*PRF_W +: PRF_W]      = pick[k*PRF_W +: PRF_W];
                prev_prd[i*PRF_W +: PRF_W] = map_d[rd[i*ARF_W +: ARF_W]];
                alloc_bits[pick[k*PRF_W +: PRF_W]] = 1'b1;
                map_d[rd[i*ARF_W +: ARF_W]]        = pick[k*PRF_W +: PRF_W];
                k = k + 1;
            end
        end
        n_alloc = FCNT_W'(k);
    end

    assign free_short  = free_cnt < n_alloc;
    assign cp_full     = cp_req && (cp_count_q == (CP_W+1)'(CP_SIZE));
    assign in_ready    = reset && !recover && !free_short && !cp_full;
    assign fire        = in_valid[0] && in_ready;
    assign cp_idx      = cp_head_q + cp_count_q[CP_W-1:0];
    assign cp_take     = fire && cp_req;
    assign cp_rel      = cp_release && (cp_count_q != '0);
    assign alloc_clear = fire ? alloc_bits : '0;
    assign recover_set = cp_q[recover_idx].alloc_mask;
    assign rec_dist    = recover_idx - cp_head_q;

    always_comb begin
        logic [CP_W-1:0] d;
        cp_live = '0;
        for (int j = 0; j < CP_SIZE; j++) begin
            d          = CP_W'(j) - cp_head_q;
            cp_live[j] = {1'b0, d} < cp_count_q;
        end
    end

    rename_freelist #(
        .WIDTH    (WIDTH),
        .ARF_SIZE (ARF_SIZE),
        .PRF_SIZE (PRF_SIZE)
    ) u_freelist (
        .clock        (clock),
        .reset        (reset),
        .alloc_clear  (alloc_clear),
        .recover      (recover),
        .recover_set  (recover_set),
        .retire_valid (retire_valid),
        .retire_prf   (retire_prf),
        .pick         (pick),
        .free_cnt     (free_cnt)
    );

    always_ff @(posedge clock) begin
        if (!reset) begin
            map_q      <= reset_map();
            cp_head_q  <= '0;
            cp_count_q <= '0;
            for (int j = 0; j < CP_SIZE; j++) begin
                cp_q[j] <= '{map: reset_map(), alloc_mask: '0};
            end
        end else if (recover) begin
            // The restored checkpoint's allocations are back in the free list, so its mask restarts.
            map_q                         <= cp_q[recover_idx].map;
            cp_q[recover_idx].alloc_mask  <= '0;
            if (cp_release) begin
                cp_head_q  <= cp_head_q + 1'b1;
                cp_count_q <= {1'b0, rec_dist};
            end else begin
                cp_count_q <= {1'b0, rec_dist} + 1'b1;
            end
        end else begin
            if (fire) begin
                map_q <= map_d;
                for (int j = 0; j < CP_SIZE; j++) begin
                    if (cp_live[j]) begin
                        cp_q[j].alloc_mask <= cp_q[j].alloc_mask | alloc_clear;
                    end
                end
                if (cp_req) begin
                    cp_q[cp_idx] <= '{map: map_d, alloc_mask: '0};
                end
            end
            if (cp_rel) begin
                cp_head_q <= cp_head_q + 1'b1;
            end
            cp_count_q <= cp_count_q + (CP_W+1)'(cp_take) - (CP_W+1)'(cp_rel);
        end
    end

`ifdef RENAME_STALL_CNT_EN
    always_ff @(posedge clock) begin
        if (!reset) begin
            stall_free_cnt <= '0;
            stall_cp_cnt   <= '0;
        end else if (in_valid[0] && !in_ready) begin
            if (free_short) begin
                if (stall_free_cnt != '1) begin
                    stall_free_cnt <= stall_free_cnt + 1'b1;
                end
            end else if (cp_full) begin
                if (stall_cp_cnt != '1) begin
                    stall_cp_cnt <= stall_cp_cnt + 1'b1;
                end
            end
        end
    end
`endif

endmodule

// File: tb/tb_rename_map_ckpt.sv
// Bench for rename_map_ckpt: directed scenarios plus random traffic against a behavioural model.
module tb_rename_map_ckpt;

    localparam int W  = 4;
    localparam int AW = 5;
    localparam int PW = 6;
    localparam int CW = 2;
    localparam int NA = 32;
    localparam int NP = 64;
    localparam int NC = 4;

    logic            clock = 1'b0;
    logic            reset;
    logic [W-1:0]    in_valid, rd_valid, retire_valid;
    logic [W*AW-1:0] rs1, rs2, rd;
    logic            cp_req, cp_release, recover;
    logic [CW-1:0]   recover_idx, cp_idx;
    logic [W*PW-1:0] retire_prf, prs1, prs2, prd, prev_prd;
    logic            in_ready;

    int n_checks = 0;
    int n_errors = 0;

    int o_prs1[W], o_prs2[W], o_prd[W], o_prev[W];
    int o_ready, o_cpidx;

    int m_map[NA];
    bit m_free[NP];
    int m_cpmap[NC][NA];
    bit m_cpalloc[NC][NP];
    int m_head, m_count;

    always #5 clock = ~clock;

    rename_map_ckpt dut (
        .clock        (clock),
        .reset        (reset),
        .in_valid     (in_valid),
        .rs1          (rs1),
        .rs2          (rs2),
        .rd           (rd),
        .rd_valid     (rd_valid),
        .cp_req       (cp_req),
        .cp_release   (cp_release),
        .recover      (recover),
        .recover_idx  (recover_idx),
        .retire_valid (retire_valid),
        .retire_prf   (retire_prf),
        .in_ready     (in_ready),
        .prs1         (prs1),
        .prs2         (prs2),
        .prd          (prd),
        .prev_prd     (prev_prd),
        .cp_idx       (cp_idx)
    );

    task automatic check_val(string tag, int got, int exp);
        n_checks++;
        if (got != exp) begin
            n_errors++;
            $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
        end
    endtask

    function automatic void model_reset();
        for (int a = 0; a < NA; a++) m_map[a] = a;
        for (int p = 0; p < NP; p++) m_free[p] = (p >= NA);
        for (int j = 0; j < NC; j++)
            for (int p = 0; p < NP; p++) m_cpalloc[j][p] = 1'b0;
        m_head  = 0;
        m_count = 0;
    endfunction

    function automatic bit is_live(int j);
        return ((j - m_head + NC) % NC) < m_count;
    endfunction

    task automatic clear_inputs();
        reset = 1'b1; in_valid = '0; rd_valid = '0; rs1 = '0; rs2 = '0; rd = '0;
        cp_req = 1'b0; cp_release = 1'b0; recover = 1'b0; recover_idx = '0;
        retire_valid = '0; retire_prf = '0;
    endtask

    task automatic set_slot(int i, int r1, int r2, int d, bit dv);
        in_valid[i]        = 1'b1;
        rs1[i*AW +: AW]    = AW'(r1);
        rs2[i*AW +: AW]    = AW'(r2);
        rd[i*AW +: AW]     = AW'(d);
        rd_valid[i]        = dv;
    endtask

    // One clock: compare DUT outputs with the model at negedge, then advance the model.
    task automatic do_cycle();
        int  tm[NA];
        bit  taken[NP];
        int  nalloc, fcnt, exp_ready, slot, ri, d, p;
        bit  fire, rel;
        @(negedge clock);
        for (int i = 0; i < W; i++) begin
            o_prs1[i] = int'(prs1[i*PW +: PW]);
            o_prs2[i] = int'(prs2[i*PW +: PW]);
            o_prd[i]  = int'(prd[i*PW +: PW]);
            o_prev[i] = int'(prev_prd[i*PW +: PW]);
        end
        o_ready = int'(in_ready);
        o_cpidx = int'(cp_idx);

        nalloc = 0;
        for (int i = 0; i < W; i++)
            if (in_valid[i] && rd_valid[i] && rd[i*AW +: AW] != 0) nalloc++;
        fcnt = 0;
        for (int q = 0; q < NP; q++) fcnt += int'(m_free[q]);
        exp_ready = (reset === 1'b1 && !recover && fcnt >= nalloc && !(cp_req && m_count == NC)) ? 1 : 0;
        check_val("in_ready", o_ready, exp_ready);
        fire = in_valid[0] && (exp_ready == 1);

        tm = m_map;
        for (int q = 0; q < NP; q++) taken[q] = 1'b0;
        if (fire) begin
            for (int i = 0; i < W; i++) begin
                if (!in_valid[i]) continue;
                check_val($sformatf("prs1[%0d]", i), o_prs1[i], tm[rs1[i*AW +: AW]]);
                check_val($sformatf("prs2[%0d]", i), o_prs2[i], tm[rs2[i*AW +: AW]]);
                if (rd_valid[i]) begin
                    d = int'(rd[i*AW +: AW]);
                    if (d != 0) begin
                        p = 0;
                        while (!(m_free[p] && !taken[p])) p++;
                        taken[p] = 1'b1;
                        check_val($sformatf("prd[%0d]", i), o_prd[i], p);
                        check_val($sformatf("prev_prd[%0d]", i), o_prev[i], tm[d]);
                        tm[d] = p;
                    end else begin
                        check_val($sformatf("prd_x0[%0d]", i), o_prd[i], 0);
                        check_val($sformatf("prev_x0[%0d]", i), o_prev[i], 0);
                    end
                end
            end
            if (cp_req) check_val("cp_idx", o_cpidx, (m_head + m_count) % NC);
        end

        if (reset !== 1'b1) begin
            model_reset();
        end else begin
            if (recover) begin
                ri = int'(recover_idx);
                m_map = m_cpmap[ri];
                for (int q = 0; q < NP; q++) begin
                    if (m_cpalloc[ri][q]) m_free[q] = 1'b1;
                    m_cpalloc[ri][q] = 1'b0;
                end
                m_count = ((ri - m_head + NC) % NC) + 1;
                if (cp_release) begin
                    m_head = (m_head + 1) % NC;
                    m_count--;
                end
            end else begin
                rel = cp_release && m_count > 0;
                if (fire) begin
                    for (int j = 0; j < NC; j++)
                        if (is_live(j))
                            for (int q = 0; q < NP; q++) m_cpalloc[j][q] |= taken[q];
                    m_map = tm;
                    for (int q = 0; q < NP; q++) if (taken[q]) m_free[q] = 1'b0;
                    if (cp_req) begin
                        slot = (m_head + m_count) % NC;
                        m_cpmap[slot] = tm;
                        for (int q = 0; q < NP; q++) m_cpalloc[slot][q] = 1'b0;
                        m_count++;
                    end
                end
                if (rel) begin
                    m_head = (m_head + 1) % NC;
                    m_count--;
                end
            end
            for (int i = 0; i < W; i++)
                if (retire_valid[i]) m_free[retire_prf[i*PW +: PW]] = 1'b1;
        end
        @(posedge clock);
        #1;
    endtask

    task automatic apply_reset();
        reset = 1'b0;
        do_cycle();
        do_cycle();
        reset = 1'b1;
    endtask

    task automatic random_cycle();
        int n, idx, val;
        bit inuse[NP];
        int cand[$];
        clear_inputs();
        n = $urandom_range(0, W);
        for (int i = 0; i < n; i++)
            set_slot(i, $urandom_range(0, NA-1), $urandom_range(0, NA-1),
                     $urandom_range(0, NA-1), ($urandom % 4) != 0);
        cp_req = ($urandom % 4) == 0;
        if (m_count > 0 && ($urandom % 8) == 0) cp_release = 1'b1;
        if (m_count > 0 && ($urandom % 12) == 0) begin
            recover     = 1'b1;
            recover_idx = CW'((m_head + $urandom_range(0, m_count-1)) % NC);
        end
        for (int q = 0; q < NP; q++) inuse[q] = 1'b0;
        for (int a = 0; a < NA; a++) inuse[m_map[a]] = 1'b1;
        for (int j = 0; j < NC; j++)
            if (is_live(j))
                for (int a = 0; a < NA; a++) inuse[m_cpmap[j][a]] = 1'b1;
        for (int q = 1; q < NP; q++)
            if (!m_free[q] && !inuse[q]) cand.push_back(q);
        for (int i = 0; i < W; i++) begin
            if (cand.size() > 0 && ($urandom % 2) == 0) begin
                idx = $urandom_range(0, cand.size()-1);
                val = cand[idx];
                cand.delete(idx);
                retire_valid[i]         = 1'b1;
                retire_prf[i*PW +: PW]  = PW'(val);
            end
        end
        if (($urandom % 500) == 0) reset = 1'b0;
        do_cycle();
    endtask

    initial begin
        model_reset();
        clear_inputs();
        apply_reset();

        // Four fresh allocations
        for (int i = 0; i < W; i++) set_slot(i, 0, 0, i + 1, 1'b1);
        do_cycle();
        check_val("t1_ready", o_ready, 1);
        for (int i = 0; i < W; i++) begin
            check_val("t1_prd", o_prd[i], 32 + i);
            check_val("t1_prev", o_prev[i], i + 1);
        end

        // Intra-group RAW and WAW
        clear_inputs();
        apply_reset();
        set_slot(0, 0, 0, 5, 1'b1);
        set_slot(1, 5, 0, 5, 1'b1);
        do_cycle();
        check_val("t2_prs1", o_prs1[1], 32);
        check_val("t2_prev", o_prev[1], 32);
        check_val("t2_prd", o_prd[1], 33);
        clear_inputs();
        set_slot(0, 5, 0, 0, 1'b0);
        do_cycle();
        check_val("t2_map5", o_prs1[0], 33);

        // Checkpoint, two groups, recover
        clear_inputs();
        set_slot(0, 0, 0, 6, 1'b1);
        cp_req = 1'b1;
        do_cycle();
        check_val("t3_cpidx", o_cpidx, 0);
        check_val("t3_prd6", o_prd[0], 34);
        clear_inputs();
        set_slot(0, 0, 0, 7, 1'b1);
        set_slot(1, 0, 0, 8, 1'b1);
        do_cycle();
        do_cycle();
        check_val("t3_prd8", o_prd[1], 38);
        clear_inputs();
        recover = 1'b1;
        recover_idx = '0;
        do_cycle();
        check_val("t3_rec_ready", o_ready, 0);
        clear_inputs();
        set_slot(0, 7, 8, 0, 1'b0);
        set_slot(1, 6, 0, 0, 1'b0);
        do_cycle();
        check_val("t3_map7", o_prs1[0], 7);
        check_val("t3_map8", o_prs2[0], 8);
        check_val("t3_map6", o_prs1[1], 34);

        // Fill the ring; freed registers come back in order
        clear_inputs();
        cp_req = 1'b1;
        for (int i = 0; i < W; i++) set_slot(i, 0, 0, 9 + i, 1'b1);
        do_cycle();
        check_val("t4_cpidx1", o_cpidx, 1);
        check_val("t4_reuse0", o_prd[0], 35);
        check_val("t4_reuse3", o_prd[3], 38);
        for (int c = 2; c < 4; c++) begin
            clear_inputs();
            cp_req = 1'b1;
            set_slot(0, 0, 0, 11 + c, 1'b1);
            do_cycle();
            check_val("t4_cpidx", o_cpidx, c);
        end
        clear_inputs();
        cp_req = 1'b1;
        set_slot(0, 0, 0, 20, 1'b1);
        do_cycle();
        check_val("t4_full", o_ready, 0);
        cp_release = 1'b1;
        do_cycle();
        check_val("t4_full_rel", o_ready, 0);
        cp_release = 1'b0;
        do_cycle();
        check_val("t4_accept", o_ready, 1);
        check_val("t4_wrap_idx", o_cpidx, 0);

        // Drain the free list to one entry, stall, retire 40
        clear_inputs();
        apply_reset();
        for (int g = 0; g < 8; g++) begin
            clear_inputs();
            for (int i = 0; i < ((g < 7) ? 4 : 3); i++) set_slot(i, 0, 0, 1 + i, 1'b1);
            do_cycle();
        end
        clear_inputs();
        set_slot(0, 0, 0, 9, 1'b1);
        set_slot(1, 0, 0, 10, 1'b1);
        retire_valid[0]  = 1'b1;
        retire_prf[0 +: PW] = PW'(40);
        do_cycle();
        check_val("t5_stall", o_ready, 0);
        retire_valid = '0;
        do_cycle();
        check_val("t5_accept", o_ready, 1);
        check_val("t5_prd0", o_prd[0], 40);
        check_val("t5_prd1", o_prd[1], 63);

        // x0 never allocates
        clear_inputs();
        set_slot(0, 0, 0, 0, 1'b1);
        do_cycle();
        check_val("t6_ready", o_ready, 1);
        check_val("t6_prd", o_prd[0], 0);
        check_val("t6_prs1", o_prs1[0], 0);
        clear_inputs();
        set_slot(0, 0, 0, 3, 1'b1);
        do_cycle();
        check_val("t6_empty", o_ready, 0);

        // Random traffic
        clear_inputs();
        apply_reset();
        for (int c = 0; c < 3000; c++) random_cycle();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/rename_map_ckpt.md
Name: rename_map_ckpt

Overview:
- Parametrised next-generation register rename stage for the integer pipeline, between decode and dispatch.
- Renames up to WIDTH micro-ops per cycle and owns the ARF-to-PRF map table, a bitmap free list and a ring of branch checkpoints.
- Supports single-cycle recovery to any live checkpoint and retire-time release of physical registers.
- Adds intra-group RAW/WAW forwarding, x0 pinning and checkpoint ring management.

Parameters:
- WIDTH, 4: micro-ops renamed per cycle.
- ARF_SIZE, 32: architectural integer registers.
- PRF_SIZE, 64: physical integer registers; must exceed ARF_SIZE+WIDTH.
- CP_SIZE, 4: checkpoint ring depth, power of two.

Ports:
- clock  in  1  rising-edge clock.
- reset  in  1  synchronous, active-low reset.
- in_valid  in  WIDTH  slot i holds a micro-op; slots are contiguous from 0.
- rs1, rs2, rd  in  WIDTH x log2(ARF_SIZE)  architectural indices per slot.
- rd_valid  in  WIDTH  slot writes rd.
- cp_req  in  1  group contains a branch; take a checkpoint of the post-group map.
- in_ready  out  1  group is accepted this cycle.
- prs1, prs2, prd, prev_prd  out  WIDTH x log2(PRF_SIZE)  renamed indices; prev_prd is the mapping of rd before this slot.
- cp_idx  out  log2(CP_SIZE)  checkpoint index assigned to this group.
- cp_release  in  1  oldest checkpoint resolved correctly; free its slot.
- recover  in  1  mispredict: restore checkpoint recover_idx.
- recover_idx  in  log2(CP_SIZE)  checkpoint to restore.
- retire_valid  in  WIDTH  slot retiring with a freeable physical register.
- retire_prf  in  WIDTH x log2(PRF_SIZE)  physical register returned to the free list.

Behaviour:
- Reset (reset==0 at clock edge):
  - map[a]=a for every a.
  - Free bitmap: set for p >= ARF_SIZE, clear otherwise.
  - cp_head=0, cp_count=0, all alloc masks cleared.
  - in_ready=0 during reset.
  - Reset mid-operation discards everything in flight.
- Outputs are combinational from the current state and inputs. A group fires when in_valid[0] && in_ready; state updates at that edge. Output values are don't-care when the group does not fire.
- in_ready=0 whenever any of these holds:
  - recover=1;
  - free count < number of slots with in_valid&rd_valid&rd!=0;
  - cp_req=1 and cp_count==CP_SIZE.
  The whole group stalls; there is no partial acceptance.
- Allocation: the k-th allocating slot takes the k-th lowest set free bit. rd==0 never allocates: prd=0, prev_prd=0, map unchanged.
- Source lookup for slot i uses the map as updated by allocating slots j<i with a matching rd. The youngest earlier writer wins (RAW forwarding).
- prev_prd[i] follows the same rule (WAW chaining). The final map takes the youngest writer per rd.
- Checkpoints:
  - When cp_req fires, the post-group map is stored at slot (cp_head+cp_count) mod CP_SIZE, cp_idx is set to that slot, and cp_count increments.
  - Each live checkpoint keeps an alloc_mask of PRFs allocated after it was taken. Every firing group ORs its allocations into the masks of all live checkpoints; a new checkpoint starts with a zero mask.
- cp_release: cp_head++, cp_count--. Ignored when cp_count==0.
- recover:
  - map <= checkpoint[recover_idx].
  - free |= alloc_mask[recover_idx].
  - cp_count <= distance(cp_head, recover_idx)+1, which discards younger checkpoints.
  - recover has priority over rename.
- Simultaneous recover and cp_release on the same slot: the release is applied after the recover, so cp_count may reach 0.
- Retire: each valid retire_prf sets its free bit at the edge. This is applied in every cycle, including recover and stall cycles, and is ORed with the recover restore.
- Retiring p0, or a PRF that is already free, is illegal; it is checked only by an assertion.

Optional Feature:
- Macro RENAME_STALL_CNT_EN.
- When defined:
  - Adds outputs stall_free_cnt and stall_cp_cnt, each 32 bits.
  - They count cycles with in_valid[0]=1 and in_ready=0, split by cause. Free-list shortage takes precedence when both causes are present.
  - Both counters saturate and are cleared on reset.
- When undefined: the ports and logic are absent and behaviour is otherwise identical.

Decomposition:
- Shared package (rename_pkg):
  - Index widths derived from ARF_SIZE, PRF_SIZE and CP_SIZE.
  - Typedefs map_t (ARF_SIZE x prf index) and cp_entry_t {map_t map; PRF_SIZE-bit alloc_mask}.
- One sub-module, rename_freelist: the bitmap with WIDTH-way lowest-set-bit picking, free count, retire set and recover OR-in.

Test Plan:
- Reset, then rename rd={1,2,3,4} with no sources → prd={32,33,34,35}, prev_prd={1,2,3,4}, free count 28.
- Group rd={5,5,-,-}, slot1 rs1=5 → slot1 prs1=32, slot1 prev_prd=32, final map[5]=33.
- cp_req with rd={6}, then rename rd={7,8} twice, then recover to that checkpoint → map[7]=7, map[8]=8, the four PRFs are back in the free list, cp_count=1.
- Fill CP_SIZE=4 checkpoints, then present cp_req → in_ready=0; assert cp_release → accepted the next cycle with cp_idx=0.
- Drain the free list to 1 entry, then present a 2-allocation group → stall; retire_prf=40 in the same cycle → accepted the next cycle.
- rd=0, rs1=0 → prd=0, prs1=0, no allocation, free count unchanged.
